mul_div_unit: RTL and testbench

Iterative 16-bit unsigned multiply/divide unit in the execute stage, beside the single-cycle ALU. It accepts operands from the ID/EX latch, takes a fixed number of cycles to compute, and returns a result plus Zero/Sign flags matching the ALU's flag semantics. Its result is muxed with the ALU output into the EX/MEM latch. While it computes, it raises a stall that freezes the front of the pipeline.

---
 rtl/mul_div_unit_if.sv | 17 +
 rtl/mul_div_unit.sv | 96 +++++++++
 tb/tb_mul_div_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/result bundle between the ID/EX stage and the multiply/divide unit.
interface mul_div_unit_if #(parameter int WIDTH = 16);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             dz;
  logic             ZF;
  logic             SF;
  modport master (output start, op, in_a, in_b, flush, input busy, stall, done, result, dz, ZF, SF);
  modport slave  (input start, op, in_a, in_b, flush, output busy, stall, done, result, dz, ZF, SF);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned shift-add multiply / restoring divide with pipeline stall.
// Optional MULDIV_EARLY_EXIT_EN ends a multiply once the remaining multiplier bits are zero.
module mul_div_unit #(parameter int WIDTH = 16) (
  input logic            clk,
  input logic            rst_n,
  mul_div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]         state_q, state_d, op_q, op_d;
  logic [WIDTH-1:0]   m_q, m_d, result_q, result_d, quo, sel, fin;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod, divs, step;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               dzp_q, dzp_d, dz_q, dz_d, accept, last, early;
  logic [WIDTH:0]     sum, rem;
  logic [WIDTH+1:0]   diff;
`ifdef MULDIV_EARLY_EXIT_EN
  logic [CW-1:0]      left;
  logic [WIDTH-1:0]   mask;
`endif
  // acc holds {product high, product low/multiplier} or {remainder, quotient/dividend}
  always_comb begin
    accept = bus.start && !bus.flush && state_q != RUN;
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    prod = {sum, acc_q[WIDTH-1:1]};
    rem = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff = {1'b0, rem} - {2'b0, m_q};
    quo = {acc_q[WIDTH-2:0], ~diff[WIDTH+1]};
    divs = diff[WIDTH+1] ? {rem[WIDTH-1:0], quo} : {diff[WIDTH-1:0], quo};
`ifdef MULDIV_EARLY_EXIT_EN
    left = cnt_q - CW'(1);
    mask = (WIDTH'(1) << left) - WIDTH'(1);
    early = !op_q[1] && (prod[WIDTH-1:0] & mask) == '0;
    step = op_q[1] ? divs : (early ? prod >> left : prod);
`else
    early = 1'b0;
    step = op_q[1] ? divs : prod;
`endif
    last = cnt_q == CW'(1) || early;
    sel = op_q[0] ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
    fin = dzp_q ? (op_q[0] ? acc_q[WIDTH-1:0] : '1) : sel;
    state_d = state_q;
    op_d = op_q;
    m_d = m_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    dzp_d = dzp_q;
    result_d = result_q;
    dz_d = dz_q;
    if (bus.flush) state_d = IDLE;
    else if (accept) begin
      state_d = RUN;
      op_d = bus.op;
      m_d = bus.op[1] ? bus.in_b : bus.in_a;
      acc_d = {{WIDTH{1'b0}}, bus.op[1] ? bus.in_a : bus.in_b};
      dzp_d = bus.op[1] && bus.in_b == '0;
      cnt_d = dzp_d ? CW'(1) : CW'(WIDTH);
    end else if (state_q == RUN) begin
      acc_d = step;
      cnt_d = cnt_q - CW'(1);
      if (last) begin
        state_d = DONE;
        result_d = fin;
        dz_d = dzp_q;
      end
    end else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= '0;
      m_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      dzp_q <= 1'b0;
      result_q <= '0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      m_q <= m_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      dzp_q <= dzp_d;
      result_q <= result_d;
      dz_q <= dz_d;
    end
  end
  assign bus.busy = state_q == RUN;
  assign bus.stall = accept || bus.busy;
  assign bus.done = state_q == DONE && !bus.flush;
  assign bus.result = result_q;
  assign bus.dz = dz_q;
  assign bus.ZF = result_q == '0;
  assign bus.SF = result_q[WIDTH-1];
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit checked against an arithmetic model every cycle.
module tb_mul_div_unit;
  localparam int W = 16;
`ifdef MULDIV_EARLY_EXIT_EN
  localparam int L56 = 8, L1234 = 14, L5 = 4;
`else
  localparam int L56 = 17, L1234 = 17, L5 = 17;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  mul_div_unit_if #(.WIDTH(W)) bus();
  mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {dz, result} from plain arithmetic
  function automatic logic [16:0] model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    if (op == 2'd0) return {1'b0, p[15:0]};
    if (op == 2'd1) return {1'b0, p[31:16]};
    if (b == 16'd0) return {1'b1, op[0] ? a : 16'hFFFF};
    return {1'b0, op[0] ? a % b : a / b};
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [15:0] b);
    if (op[1] && b == 16'd0) return 2;
`ifdef MULDIV_EARLY_EXIT_EN
    if (!op[1]) begin
      for (int i = W - 1; i >= 0; i--) if (b[i]) return i + 2;
      return 2;
    end
`endif
    return W + 1;
  endfunction

  bit active = 1'b0;
  int cyc = 0, e_lat = 0;
  logic [15:0] e_res = '0, held = '0;
  logic e_dz = 1'b0, held_dz = 1'b0;
  always @(negedge clk) begin : cmp
    logic bexp, dexp, acc, d;
    logic [15:0] r;
    if (!rst_n) begin
      chk("rst_result", bus.result, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_dz", bus.dz, 0);
      chk("rst_stall", bus.stall, 0);
      active = 1'b0;
      held = '0;
      held_dz = 1'b0;
    end else begin
      bexp = active && cyc < e_lat;
      dexp = active && cyc == e_lat;
      acc = bus.start && !bus.flush && !bexp;
      r = dexp ? e_res : held;
      d = dexp ? e_dz : held_dz;
      chk("busy", bus.busy, bexp);
      chk("done", bus.done, dexp);
      chk("stall", bus.stall, bexp || acc);
      chk("result", bus.result, r);
      chk("dz", bus.dz, d);
      chk("ZF", bus.ZF, r == 16'd0);
      chk("SF", bus.SF, r[15]);
      if (dexp) begin
        held = e_res;
        held_dz = e_dz;
      end
      if (bus.flush) active = 1'b0;
      else if (acc) begin
        {e_dz, e_res} = model(bus.op, bus.in_a, bus.in_b);
        e_lat = model_lat(bus.op, bus.in_b);
        cyc = 1;
        active = 1'b1;
      end else if (active) begin
        if (dexp) active = 1'b0;
        else cyc++;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.start = 1'b1;
    bus.op = op;
    bus.in_a = a;
    bus.in_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op = op ^ 2'b11;
    bus.in_a = 16'hA5A5;
    bus.in_b = 16'h0000;
  endtask

  task automatic wait_done(input string name, input logic [15:0] lit, input int lit_lat);
    int lat;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.done) chk({name, "_timeout"}, 0, 1);
    else begin
      chk(name, bus.result, lit);
      chk({name, "_lat"}, lat, lit_lat);
    end
  endtask

  typedef struct {logic [1:0] op; logic [15:0] a, b, r; int lat;} vec_t;
  vec_t vt[10];

  initial begin
    vt = '{'{2'd0, 16'h1234, 16'h0056, 16'h1D78, L56},
           '{2'd1, 16'h1234, 16'h0056, 16'h0006, L56},
           '{2'd2, 16'hFFFF, 16'h0007, 16'h2492, 17},
           '{2'd3, 16'hFFFF, 16'h0007, 16'h0001, 17},
           '{2'd2, 16'h1234, 16'h0000, 16'hFFFF, 2},
           '{2'd3, 16'h1234, 16'h0000, 16'h1234, 2},
           '{2'd0, 16'h0000, 16'h1234, 16'h0000, L1234},
           '{2'd1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17},
           '{2'd2, 16'h0064, 16'h0007, 16'h000E, 17},
           '{2'd3, 16'h0064, 16'h0007, 16'h0002, 17}};
    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("model_mul", model(2'd0, 16'h1234, 16'h0056), 17'h01D78);
    chk("model_mulhu", model(2'd1, 16'h1234, 16'h0056), 17'h00006);
    chk("model_divu", model(2'd2, 16'hFFFF, 16'h0007), 17'h02492);
    chk("model_divz", model(2'd2, 16'h1234, 16'h0000), 17'h1FFFF);
    foreach (vt[i]) begin
      issue(vt[i].op, vt[i].a, vt[i].b);
      wait_done($sformatf("vec%0d", i), vt[i].r, vt[i].lat);
      @(posedge clk); #1;
    end
    issue(2'd0, 16'h1234, 16'h0056);
    wait_done("b2b_first", 16'h1D78, L56);
    issue(2'd0, 16'h0003, 16'h0005);
    wait_done("b2b_second", 16'h000F, L5);
    @(posedge clk); #1;
    issue(2'd0, 16'h0007, 16'h0009);
    repeat (4) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    repeat (25) @(posedge clk);
    #1 chk("flush_result", bus.result, 16'h000F);
    chk("flush_busy", bus.busy, 0);
    bus.flush = 1'b1;
    bus.start = 1'b1;
    bus.op = 2'd0;
    bus.in_a = 16'h0003;
    bus.in_b = 16'h0003;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("flush_start_busy", bus.busy, 0);
    chk("flush_start_result", bus.result, 16'h000F);
    issue(2'd2, 16'hFFFF, 16'h0007);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("async_rst_result", bus.result, 0);
    chk("async_rst_busy", bus.busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(2'd2, 16'hFFFF, 16'h0007);
    wait_done("after_rst", 16'h2492, 17);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
